forward_unit: RTL and testbench
===============================

# forward_unit

Registered forwarding and load-use hazard controller for the five-stage RISC-V pipeline. It tracks the destination register of every instruction in EX, MEM and WB, and computes the `forwardA`/`forwardB` select codes consumed by the EX-stage ALU operand muxes. It raises a load-use stall and inserts bubbles on stall or branch flush. It sits between the ID/EX pipeline register and the EX-stage operand selection.

## Interface
- `REG_W`, 5: register index width.
- `clock` in 1: pipeline clock; all state updates on rising edge.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `ID_rs1` in `REG_W`: source 1 index of the instruction in ID.
- `ID_rs2` in `REG_W`: source 2 index of the instruction in ID.
- `ID_rd` in `REG_W`: destination index of the instruction in ID.
- `ID_usesRs1` in 1: the ID instruction reads rs1.
- `ID_usesRs2` in 1: the ID instruction reads rs2.
- `ID_regWrite` in 1: the ID instruction writes rd.
- `ID_memRead` in 1: the ID instruction is a load.
- `flush` in 1: taken branch/jump resolved in EX; the ID instruction must not enter EX.
- `forwardA` out 2: EX operand-A select. 0 = regfile, 1 = WB `dataD`, 2 = MEM `aluResult`. 3 is never driven.
- `forwardB` out 2: EX operand-B select, same encoding as `forwardA`.
- `stall` out 1: hold PC and IF/ID; combinational from current state and ID inputs.
- `EX_rd`, `MEM_rd`, `WB_rd` out `REG_W`: tracked destinations, for debug.
- `EX_wr`, `MEM_wr`, `WB_wr` out 1: the corresponding slot will write a register.

## Operation
- Three slots, EX, MEM and WB, each holding {rd, regWrite, memRead}. A slot "writes r" when regWrite=1, rd=r and rd≠0.
- Each edge, MEM→WB and EX→MEM always advance. EX loads the ID info, or a bubble (all zero) when `stall` or `flush` is set.
- `stall` = !flush AND EX.memRead AND EX writes r AND ((ID_usesRs1 AND r=ID_rs1) OR (ID_usesRs2 AND r=ID_rs2)). Flush overrides stall.
- Next forward code for each source, computed in ID from the current slots:
  - If the EX slot writes rs and EX.memRead=0, the code is 2.
  - Else if the MEM slot writes rs, the code is 1.
  - Else the code is 0.
  - The code is also 0 when the source is unused, or when a bubble is being inserted.
- The codes are registered into `forwardA`/`forwardB` on the same edge that loads the EX slot. They are therefore valid for the whole cycle the instruction occupies EX.
- Reads of a register being written by the WB slot during ID are resolved by the register file's write-through; this block does not forward from WB into ID.
- x0 never forwards and never stalls.

## Timing
- Reset values: all slots zero, `forwardA`=`forwardB`=0, `stall`=0, all debug outputs 0.
- Reset asserted mid-operation clears all state immediately, asynchronously. The first edge after release loads EX from the ID inputs.
- Forward codes have 1-cycle latency from the ID inputs.
- `stall` has 0-cycle latency and lasts exactly one cycle per load-use hazard. Upstream holds the ID inputs stable during the stall. On the next cycle the load is in MEM and the hazard resolves as code 1.
- Back-to-back producers: the nearest producer (EX slot) wins over MEM.
- `flush` and `stall` in the same cycle: bubble inserted, `stall`=0.

## Structure
- Shared `riscv_pkg`:
  - constants `FWD_REG`=2'd0, `FWD_WB`=2'd1, `FWD_MEM`=2'd2;
  - packed typedef `hz_slot_t` {rd, regWrite, memRead};
  - bubble constant `HZ_BUBBLE`.
- One sub-module `fwd_sel`: combinational per-source code computation (rs, uses, EX slot, MEM slot → 2-bit code), instantiated twice.
- Slot registers, stall logic and output registers live in the top module.

## Test plan
- Reset: after reset release with idle inputs, `forwardA`=`forwardB`=0, `stall`=0, all slots zero.
- EX→EX forwarding: `add x5` followed by `sub x6,x5,x7` gives `forwardA`=2 and `forwardB`=0 while `sub` is in EX.
- MEM→EX forwarding with priority: `add x5`, then `add x5`, then `or x8,x5,x5` gives codes 2/2 (nearest producer). With an unrelated instruction between producer and consumer, codes are 1/1.
- Load-use: `lw x9`, then `add x10,x9,x1` gives `stall`=1 for exactly one cycle and a bubble in EX. While `add` is in EX, `forwardA`=1.
- x0 and flush: producer writing x0 gives code 0 and no stall. `flush`=1 coincident with a load-use hazard gives `stall`=0, `EX_wr`=0 next cycle, and forward codes 0.
- Async reset mid-stream: assert `resetn`=0 between edges; all outputs go to 0 before the next edge.

Source files
------------

// File: rtl/forward_unit_pkg.sv
// Shared pipeline types and forwarding select codes for the EX-stage hazard logic.
package riscv_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regWrite;
        logic             memRead;
    } hz_slot_t;

    localparam hz_slot_t HZ_BUBBLE = '{rd: {REG_W{1'b0}}, regWrite: 1'b0, memRead: 1'b0};

    // x0 is hardwired, so a write to it is never a real producer
    function automatic logic slot_live(input logic wr, input logic [REG_W-1:0] rd);
        return wr && (rd != {REG_W{1'b0}});
    endfunction

    function automatic logic writes_reg(input logic wr, input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] r);
        return slot_live(wr, rd) && (rd == r);
    endfunction

endpackage

// File: rtl/forward_unit_if.sv
// ID-stage hazard inputs and EX-stage forwarding/stall outputs of forward_unit.
interface forward_unit_if;
    import riscv_pkg::*;

    logic [REG_W-1:0] ID_rs1;
    logic [REG_W-1:0] ID_rs2;
    logic [REG_W-1:0] ID_rd;
    logic             ID_usesRs1;
    logic             ID_usesRs2;
    logic             ID_regWrite;
    logic             ID_memRead;
    logic             flush;
    logic [1:0]       forwardA;
    logic [1:0]       forwardB;
    logic             stall;
    logic [REG_W-1:0] EX_rd;
    logic [REG_W-1:0] MEM_rd;
    logic [REG_W-1:0] WB_rd;
    logic             EX_wr;
    logic             MEM_wr;
    logic             WB_wr;

    modport slave (
        input  ID_rs1, ID_rs2, ID_rd, ID_usesRs1, ID_usesRs2, ID_regWrite, ID_memRead, flush,
        output forwardA, forwardB, stall, EX_rd, MEM_rd, WB_rd, EX_wr, MEM_wr, WB_wr
    );

    modport master (
        output ID_rs1, ID_rs2, ID_rd, ID_usesRs1, ID_usesRs2, ID_regWrite, ID_memRead, flush,
        input  forwardA, forwardB, stall, EX_rd, MEM_rd, WB_rd, EX_wr, MEM_wr, WB_wr
    );

endinterface

// File: rtl/forward_unit_fwd_sel.sv
// Per-source forward select: nearest non-load producer in EX wins, then MEM, else regfile.
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_uses,
    input  hz_slot_t         i_ex,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_wr,
    output logic [1:0]       o_code
);

    // A load in EX has no data yet; that case is covered by the stall, not by forwarding
    always_comb begin
        o_code = FWD_REG;
        if (!i_uses) begin
            o_code = FWD_REG;
        end else if (writes_reg(i_ex.regWrite, i_ex.rd, i_rs) && !i_ex.memRead) begin
            o_code = FWD_MEM;
        end else if (writes_reg(i_mem_wr, i_mem_rd, i_rs)) begin
            o_code = FWD_WB;
        end else begin
            o_code = FWD_REG;
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Tracks EX/MEM/WB destinations, registers EX operand forward selects and
// raises a one-cycle load-use stall; stall and flush both insert a bubble into EX.
module forward_unit
    import riscv_pkg::*;
(
    input logic           clock,
    input logic           resetn,
    forward_unit_if.slave bus
);

    hz_slot_t         r_ex;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_wr;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_wr;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;

    hz_slot_t         w_id_slot;
    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic [1:0]       w_code_a;
    logic [1:0]       w_code_b;

    assign w_id_slot = '{rd: bus.ID_rd, regWrite: bus.ID_regWrite, memRead: bus.ID_memRead};

    // Load-use detection against the instruction currently in EX; flush wins
    always_comb begin
        w_hazard = (bus.ID_usesRs1 && writes_reg(r_ex.regWrite, r_ex.rd, bus.ID_rs1)) ||
                   (bus.ID_usesRs2 && writes_reg(r_ex.regWrite, r_ex.rd, bus.ID_rs2));
        w_stall  = 1'b0;
        if (bus.flush) begin
            w_stall = 1'b0;
        end else if (r_ex.memRead && w_hazard) begin
            w_stall = 1'b1;
        end else begin
            w_stall = 1'b0;
        end
        w_bubble = w_stall || bus.flush;
    end

    fwd_sel u_fwd_a (
        .i_rs     (bus.ID_rs1),
        .i_uses   (bus.ID_usesRs1),
        .i_ex     (r_ex),
        .i_mem_rd (r_mem_rd),
        .i_mem_wr (r_mem_wr),
        .o_code   (w_code_a)
    );

    fwd_sel u_fwd_b (
        .i_rs     (bus.ID_rs2),
        .i_uses   (bus.ID_usesRs2),
        .i_ex     (r_ex),
        .i_mem_rd (r_mem_rd),
        .i_mem_wr (r_mem_wr),
        .o_code   (w_code_b)
    );

    // Slot advance and forward-select registers share the edge that loads EX
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ex     <= HZ_BUBBLE;
            r_mem_rd <= {REG_W{1'b0}};
            r_mem_wr <= 1'b0;
            r_wb_rd  <= {REG_W{1'b0}};
            r_wb_wr  <= 1'b0;
            r_fwd_a  <= FWD_REG;
            r_fwd_b  <= FWD_REG;
        end else begin
            r_wb_rd  <= r_mem_rd;
            r_wb_wr  <= r_mem_wr;
            r_mem_rd <= r_ex.rd;
            r_mem_wr <= r_ex.regWrite;
            if (w_bubble) begin
                r_ex    <= HZ_BUBBLE;
                r_fwd_a <= FWD_REG;
                r_fwd_b <= FWD_REG;
            end else begin
                r_ex    <= w_id_slot;
                r_fwd_a <= w_code_a;
                r_fwd_b <= w_code_b;
            end
        end
    end

    assign bus.forwardA = r_fwd_a;
    assign bus.forwardB = r_fwd_b;
    assign bus.stall    = w_stall;
    assign bus.EX_rd    = r_ex.rd;
    assign bus.MEM_rd   = r_mem_rd;
    assign bus.WB_rd    = r_wb_rd;
    assign bus.EX_wr    = slot_live(r_ex.regWrite, r_ex.rd);
    assign bus.MEM_wr   = slot_live(r_mem_wr, r_mem_rd);
    assign bus.WB_wr    = slot_live(r_wb_wr, r_wb_rd);

endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: directed instruction table, async reset check, random vs pipeline model.
module tb_forward_unit;
    import riscv_pkg::*;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    forward_unit_if bus();

    forward_unit dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw, mr, fl;
        logic       st;
        logic [1:0] fa, fb;
        logic       exwr;
    } vec_t;

    vec_t vecs[$];

    // Instruction history model: index 0 = EX, 1 = MEM, 2 = WB
    logic [4:0] m_rd[3];
    logic       m_rw[3];
    logic       m_ld[3];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int u1,
                                input int u2, input int rw, input int mr, input int fl,
                                input int st, input int fa, input int fb, input int exwr);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.u1 = 1'(u1); v.u2 = 1'(u2); v.rw = 1'(rw); v.mr = 1'(mr); v.fl = 1'(fl);
        v.st = 1'(st); v.fa = 2'(fa); v.fb = 2'(fb); v.exwr = 1'(exwr);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.ID_rs1 = v.rs1; bus.ID_rs2 = v.rs2; bus.ID_rd = v.rd;
        bus.ID_usesRs1 = v.u1; bus.ID_usesRs2 = v.u2;
        bus.ID_regWrite = v.rw; bus.ID_memRead = v.mr; bus.flush = v.fl;
    endtask

    // Called at posedge+1: drive, check combinational stall, then check registered codes
    task automatic step(input vec_t v, input int idx);
        drive(v);
        #1;
        chk($sformatf("stall[%0d]", idx), 8'(bus.stall), 8'(v.st));
        @(posedge clock);
        #1;
        chk($sformatf("fwdA[%0d]", idx), 8'(bus.forwardA), 8'(v.fa));
        chk($sformatf("fwdB[%0d]", idx), 8'(bus.forwardB), 8'(v.fb));
        chk($sformatf("EX_wr[%0d]", idx), 8'(bus.EX_wr), 8'(v.exwr));
    endtask

    function automatic logic m_writes(input int i, input logic [4:0] r);
        return m_rw[i] && (m_rd[i] == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] m_code(input logic [4:0] rs, input logic u);
        if (!u) return 2'd0;
        if (m_writes(0, rs) && !m_ld[0]) return 2'd2;
        if (m_writes(1, rs)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 8'(bus.stall), 8'd0);
        chk({tag, "_fA"}, 8'(bus.forwardA), 8'd0);
        chk({tag, "_fB"}, 8'(bus.forwardB), 8'd0);
        chk({tag, "_EXrd"}, 8'(bus.EX_rd), 8'd0);
        chk({tag, "_MEMrd"}, 8'(bus.MEM_rd), 8'd0);
        chk({tag, "_WBrd"}, 8'(bus.WB_rd), 8'd0);
        chk({tag, "_EXwr"}, 8'(bus.EX_wr), 8'd0);
        chk({tag, "_MEMwr"}, 8'(bus.MEM_wr), 8'd0);
        chk({tag, "_WBwr"}, 8'(bus.WB_wr), 8'd0);
    endtask

    initial begin
        vec_t nop, v;
        logic prev_st;
        logic [1:0] e_fa, e_fb;
        logic e_st, bub;

        nop = mk(0,0,0, 0,0,0,0,0, 0,0,0,0);
        drive(nop);
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        resetn = 1'b1;

        // rs1, rs2, rd, u1, u2, rw, mr, fl  |  stall, fwdA, fwdB, EX_wr
        vecs.push_back(mk(1,2,5, 1,1,1,0,0, 0,0,0,1));   // add x5,x1,x2
        vecs.push_back(mk(5,7,6, 1,1,1,0,0, 0,2,0,1));   // sub x6,x5,x7
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(1,2,5, 1,1,1,0,0, 0,0,0,1));   // add x5
        vecs.push_back(mk(3,4,5, 1,1,1,0,0, 0,0,0,1));   // add x5,x3,x4
        vecs.push_back(mk(5,5,8, 1,1,1,0,0, 0,2,2,1));   // or x8,x5,x5: nearest wins
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(1,2,5, 1,1,1,0,0, 0,0,0,1));   // add x5
        vecs.push_back(mk(3,4,11,1,1,1,0,0, 0,0,0,1));   // unrelated
        vecs.push_back(mk(5,5,8, 1,1,1,0,0, 0,1,1,1));   // or x8,x5,x5 from MEM
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(1,2,5, 1,1,1,0,0, 0,0,0,1));   // add x5
        vecs.push_back(mk(5,5,12,0,0,1,0,0, 0,0,0,1));   // x5 indices but unused
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(2,0,9, 1,0,1,1,0, 0,0,0,1));   // lw x9
        vecs.push_back(mk(9,1,10,1,1,1,0,0, 1,0,0,0));   // add x10,x9,x1: stall, bubble
        vecs.push_back(mk(9,1,10,1,1,1,0,0, 0,1,0,1));   // held: now from MEM
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(3,0,0, 1,0,1,1,0, 0,0,0,0));   // lw x0
        vecs.push_back(mk(0,0,10,1,1,1,0,0, 0,0,0,1));   // add x10,x0,x0
        vecs.push_back(nop); vecs.push_back(nop);
        vecs.push_back(mk(2,0,9, 1,0,1,1,0, 0,0,0,1));   // lw x9
        vecs.push_back(mk(9,9,10,1,1,1,0,1, 0,0,0,0));   // load-use with flush
        vecs.push_back(nop);

        foreach (vecs[i]) step(vecs[i], i);

        // Async reset with live state and a pending load-use hazard
        step(mk(1,2,5, 1,1,1,0,0, 0,0,0,1), 100);
        step(mk(5,0,9, 1,0,1,1,0, 0,2,0,1), 101);
        drive(mk(9,1,10,1,1,1,0,0, 0,0,0,0));
        #1;
        chk("pre_reset_stall", 8'(bus.stall), 8'd1);
        resetn = 1'b0;
        #1;
        chk_all_zero("async");
        drive(nop);
        @(posedge clock);
        #1;
        chk_all_zero("held");
        resetn = 1'b1;

        for (int k = 0; k < 3; k++) begin
            m_rd[k] = 5'd0; m_rw[k] = 1'b0; m_ld[k] = 1'b0;
        end
        prev_st = 1'b0;
        v = nop;
        for (int n = 0; n < 600; n++) begin
            if (!prev_st) begin
                v.rs1 = 5'($urandom_range(0, 3));
                v.rs2 = 5'($urandom_range(0, 3));
                v.rd  = 5'($urandom_range(0, 3));
                v.u1  = 1'($urandom_range(0, 1));
                v.u2  = 1'($urandom_range(0, 1));
                v.rw  = 1'($urandom_range(0, 3) != 0);
                v.mr  = 1'($urandom_range(0, 2) == 0);
            end
            v.fl = 1'($urandom_range(0, 7) == 0);
            e_st = !v.fl && m_ld[0] &&
                   ((v.u1 && m_writes(0, v.rs1)) || (v.u2 && m_writes(0, v.rs2)));
            bub  = e_st || v.fl;
            e_fa = bub ? 2'd0 : m_code(v.rs1, v.u1);
            e_fb = bub ? 2'd0 : m_code(v.rs2, v.u2);
            drive(v);
            #1;
            chk($sformatf("r_stall[%0d]", n), 8'(bus.stall), 8'(e_st));
            m_rd[2] = m_rd[1]; m_rw[2] = m_rw[1]; m_ld[2] = m_ld[1];
            m_rd[1] = m_rd[0]; m_rw[1] = m_rw[0]; m_ld[1] = m_ld[0];
            m_rd[0] = bub ? 5'd0 : v.rd;
            m_rw[0] = bub ? 1'b0 : v.rw;
            m_ld[0] = bub ? 1'b0 : v.mr;
            prev_st = e_st;
            @(posedge clock);
            #1;
            chk($sformatf("r_fA[%0d]", n), 8'(bus.forwardA), 8'(e_fa));
            chk($sformatf("r_fB[%0d]", n), 8'(bus.forwardB), 8'(e_fb));
            chk($sformatf("r_EXrd[%0d]", n), 8'(bus.EX_rd), 8'(m_rd[0]));
            chk($sformatf("r_MEMrd[%0d]", n), 8'(bus.MEM_rd), 8'(m_rd[1]));
            chk($sformatf("r_WBrd[%0d]", n), 8'(bus.WB_rd), 8'(m_rd[2]));
            chk($sformatf("r_EXwr[%0d]", n), 8'(bus.EX_wr), 8'(m_rw[0] && m_rd[0] != 5'd0));
            chk($sformatf("r_MEMwr[%0d]", n), 8'(bus.MEM_wr), 8'(m_rw[1] && m_rd[1] != 5'd0));
            chk($sformatf("r_WBwr[%0d]", n), 8'(bus.WB_wr), 8'(m_rw[2] && m_rd[2] != 5'd0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
